// File: rtl/mem_seq_pkg.sv
// Shared types for the memory port sequencer: FSM states, port ids, default read latency.
// The MEM_SEQ_RR_EN build option is consumed by mem_seq_pick and mem_port_sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_e;

    localparam int MEM_LAT_DEF = 2;

    // Wait-counter width; a zero-latency memory still needs a one-bit counter.
    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_seq_pick.sv
// Combinational winner selection between the fetch and data requesters.
// MEM_SEQ_RR_EN defined: ties go to the port not granted last; otherwise the data port wins ties.
module mem_seq_pick
    import mem_seq_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_port,
    output logic grant_valid,
    output logic grant_port
);

    always_comb begin
        grant_valid = if_req | dm_req;
        grant_port  = PORT_DM;
        if (!dm_req) begin
            grant_port = PORT_IF;
        end
`ifdef MEM_SEQ_RR_EN
        else if (if_req) begin
            grant_port = (last_port == PORT_DM) ? PORT_IF : PORT_DM;
        end
`endif
    end

`ifndef MEM_SEQ_RR_EN
    logic unused_last_port;
    assign unused_last_port = last_port;
`endif

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares the single-port CPU memory between instruction fetch and data load/store, absorbing read latency.
// Build option MEM_SEQ_RR_EN: round-robin tie break with a last-granted pointer (default: data port priority).
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state_out
);

    localparam int CNT_W = cnt_width(MEM_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_e             owner_q, owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              grant_valid;
    logic              grant_port;
    logic              last_port;

`ifdef MEM_SEQ_RR_EN
    logic last_q, last_d;
    assign last_port = last_q;
`else
    assign last_port = PORT_DM;
`endif

    mem_seq_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .last_port   (last_port),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
`ifdef MEM_SEQ_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = port_e'(grant_port);
                    state_d = ACCESS;
`ifdef MEM_SEQ_RR_EN
                    last_d  = grant_port;
`endif
                    if (grant_port == PORT_DM) begin
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_wr_d    = dm_we;
                        cnt_d       = dm_we ? '0 : CNT_W'(MEM_LAT);
                    end else begin
                        // fetch is always a read, whatever dm_we says
                        mem_addr_d = if_addr;
                        mem_wr_d   = 1'b0;
                        cnt_d      = CNT_W'(MEM_LAT);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!mem_wr_q) begin
                        if (owner_q == PORT_DM) dm_rdata_d = mem_rdata;
                        else                    if_rdata_d = mem_rdata;
                    end
                    mem_wr_d = 1'b0;
                    if (owner_q == PORT_DM) dm_ack_d = 1'b1;
                    else                    if_ack_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= PORT_DM;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

`ifdef MEM_SEQ_RR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_q <= PORT_DM;
        else       last_q <= last_d;
    end
`endif

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign state_out = state_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: directed scenarios plus randomized two-port traffic against a
// transaction-timestamp model. Honours MEM_SEQ_RR_EN for the tie-break expectation.
module tb_mem_port_sequencer;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] mem_rdata = '0;
    logic        if_ack, dm_ack, mem_wr, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [1:0]  state_out;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_port_sequencer #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .state_out (state_out)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Environment memory: writes land mid-cycle, read data follows the registered address.
    logic [31:0] env_mem [logic [31:0]];
    always @(negedge clock) begin
        if (mem_wr === 1'b1) env_mem[mem_addr] = mem_wdata;
        mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
    end

    // Model: one transaction at a time, described by its acceptance edge and ACCESS length.
    int          cyc = 0;
    bit          m_act = 0, m_own = 0, m_we = 0, m_last = 1;
    int          m_tacc = 0, m_dur = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
    logic [31:0] mdl_mem [logic [31:0]];

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_act   = 0;
            m_last  = 1;
            m_if_rd = '0;
            m_dm_rd = '0;
        end else begin
            cyc++;
            if (m_act && !m_we && cyc == m_tacc + m_dur) begin
                if (m_own) m_dm_rd = mdl_read(m_addr);
                else       m_if_rd = mdl_read(m_addr);
            end
            if (m_act && cyc >= m_tacc + m_dur + 2) m_act = 0;
            if (!m_act && (if_req || dm_req)) begin
                if (if_req && dm_req) begin
`ifdef MEM_SEQ_RR_EN
                    m_own = !m_last;
`else
                    m_own = 1;
`endif
                end else begin
                    m_own = dm_req;
                end
                m_we    = m_own && dm_we;
                m_addr  = m_own ? dm_addr : if_addr;
                m_wdata = dm_wdata;
                m_dur   = m_we ? 1 : LAT + 1;
                m_tacc  = cyc;
                m_act   = 1;
                m_last  = m_own;
                if (m_we) mdl_mem[m_addr] = dm_wdata;
            end
        end
    end

    always @(negedge clock) begin : cmp
        bit acc, dn;
        acc = m_act && (cyc < m_tacc + m_dur);
        dn  = m_act && (cyc == m_tacc + m_dur);
        chk("busy", {31'd0, busy}, {31'd0, acc || dn});
        chk("state_out", {30'd0, state_out}, acc ? 32'd1 : (dn ? 32'd2 : 32'd0));
        chk("if_ack", {31'd0, if_ack}, {31'd0, dn && !m_own});
        chk("dm_ack", {31'd0, dm_ack}, {31'd0, dn && m_own});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, acc && m_we});
        if (acc) chk("mem_addr", mem_addr, m_addr);
        if (acc && m_we) chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_rdata", if_rdata, m_if_rd);
        chk("dm_rdata", dm_rdata, m_dm_rd);
    end

    function automatic logic [31:0] rnd_addr();
        return 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic rand_cycles(input int n, input bit allow_new);
        bit dn, acc;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #2;
            dn  = m_act && (cyc == m_tacc + m_dur);
            acc = m_act && (cyc < m_tacc + m_dur);
            if (if_req) begin
                if (dn && !m_own) begin
                    if (!allow_new || $urandom_range(0, 3) != 0) if_req = 1'b0;
                end else if (acc && !m_own) begin
                    if_addr = rnd_addr();
                end
            end else if (allow_new && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = rnd_addr();
            end
            if (dm_req) begin
                if (dn && m_own) begin
                    if (!allow_new || $urandom_range(0, 3) != 0) dm_req = 1'b0;
                end else if (acc && m_own) begin
                    dm_addr  = rnd_addr();
                    dm_wdata = $urandom;
                    dm_we    = 1'($urandom_range(0, 1));
                end
            end else if (allow_new && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = rnd_addr();
                dm_wdata = $urandom;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, wr_cnt, wr_at, ack_at, if_seen, first, nacks, last_ack;
        reset    = 1'b1;
        if_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        if_addr  = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        env_mem[32'h40] = 32'h8C220004;
        mdl_mem[32'h40] = 32'h8C220004;

        repeat (2) @(posedge clock);
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {30'd0, state_out}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        chk("rst_ack", {30'd0, if_ack, dm_ack}, 32'd0);
        @(posedge clock); #2;
        reset = 1'b0;

        // fetch of 0x40: ack in 4th cycle after acceptance
        if_req  = 1'b1;
        if_addr = 32'h40;
        n = 0;
        while (n < 20) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (if_ack) break;
        end
        chk("fetch_ack_cycle", n, LAT + 2);
        chk("fetch_rdata", if_rdata, 32'h8C220004);
        if_req = 1'b0;

        // store 0xDEADBEEF to 0x100
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h100;
        dm_wdata = 32'hDEADBEEF;
        wr_cnt = 0; wr_at = -1; ack_at = -1; if_seen = 0;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            @(negedge clock);
            if (if_ack) if_seen++;
            if (mem_wr) begin
                wr_cnt++;
                wr_at = i;
                chk("store_addr", mem_addr, 32'h100);
                chk("store_wdata", mem_wdata, 32'hDEADBEEF);
            end
            if (dm_ack) ack_at = i;
        end
        chk("store_wr_cycles", wr_cnt, 1);
        chk("store_ack_after_wr", ack_at, wr_at + 1);
        chk("store_no_if_ack", if_seen, 0);
        dm_req = 1'b0;
        dm_we  = 1'b0;

        // load held through DONE: two identical accesses
        dm_req  = 1'b1;
        dm_addr = 32'h100;
        nacks = 0; last_ack = 0; n = 0;
        for (int i = 0; i < 40 && nacks < 2; i++) begin
            @(negedge clock);
            if (dm_ack) begin
                nacks++;
                if (nacks == 2) begin
                    n = i - last_ack;
                    dm_req = 1'b0;
                end
                last_ack = i;
            end
        end
        chk("hold_acks", nacks, 2);
        chk("hold_gap", n, LAT + 3);
        chk("hold_rdata", dm_rdata, 32'hDEADBEEF);

        // simultaneous requests straight after reset
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h40;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h104;
        first = -1; nacks = 0;
        for (int i = 0; i < 40 && nacks < 2; i++) begin
            @(negedge clock);
            if (if_ack) begin
                if (first < 0) first = 0;
                nacks++;
                if_req = 1'b0;
            end
            if (dm_ack) begin
                if (first < 0) first = 1;
                nacks++;
                dm_req = 1'b0;
            end
        end
`ifdef MEM_SEQ_RR_EN
        chk("tie_first", first, 0);
`else
        chk("tie_first", first, 1);
`endif
        chk("tie_both_served", nacks, 2);

        // reset during the second ACCESS cycle of a fetch
        @(posedge clock); #2;
        if_req  = 1'b1;
        if_addr = 32'h44;
        @(posedge clock);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_state", {30'd0, state_out}, 32'd0);
        chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("midrst_if_rdata", if_rdata, 32'd0);
        if_req = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        nacks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (if_ack) nacks++;
        end
        chk("midrst_no_ack", nacks, 0);

        rand_cycles(700, 1'b1);
        rand_cycles(30, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
